bitmap_addr_gen: RTL and testbench

//  Initiator side of the bitmap DRAM port. Holds the X/Y pixel pointer (XA/YA)
//  and drives DRBA/PIXA into the video DRAM block for CPU bitmap-mode accesses.

---
 rtl/bitmap_pkg.sv | 20 ++
 rtl/bitmap_axis_counter.sv | 44 ++++
 rtl/bitmap_addr_gen.sv | 125 ++++++++++++
 tb/tb_bitmap_addr_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bitmap_pkg.sv
// Shared types and constants for the bitmap DRAM address generator.
// Optional feature macro: BITMAP_WRAP_FLAG_EN (sticky per-axis wrap flags).
package bitmap_pkg;

  localparam int unsigned XW_DEF = 8;
  localparam int unsigned YW_DEF = 8;

  // Bit positions within the control register written through BD.
  localparam int unsigned CTL_AX   = 0;
  localparam int unsigned CTL_AY   = 1;
  localparam int unsigned CTL_XDEC = 2;
  localparam int unsigned CTL_YDEC = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } bm_state_e;

endpackage

// File: rtl/bitmap_axis_counter.sv
// One pixel-pointer axis: CPU load, post-step up/down modulo 2**W, wrap pulse.
module bitmap_axis_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         step_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // A CPU load overrides a coincident step, so it never reports a wrap.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (step_i) begin
      if (dec_i) begin
        cnt_d  = cnt_q - W'(1);
        wrap_o = (cnt_q == '0);
      end else begin
        cnt_d  = cnt_q + W'(1);
        wrap_o = &cnt_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bitmap_addr_gen.sv
// Bitmap DRAM port initiator: X/Y pointer, address mux, one post-step per access.
// Define BITMAP_WRAP_FLAG_EN to add the sticky XWRAP/YWRAP outputs.
module bitmap_addr_gen
  import bitmap_pkg::*;
#(
  parameter int unsigned XW = XW_DEF,
  parameter int unsigned YW = YW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce2Hd3,
  input  logic [14:0]        AB,
  input  logic [7:0]         BD,
  input  logic               XA_WEn,
  input  logic               YA_WEn,
  input  logic               CTL_WEn,
  input  logic               BITMDn,
  output logic [XW+YW-2:0]   DRBA,
  output logic               PIXA,
  output logic [XW-1:0]      XA_q,
  output logic [YW-1:0]      YA_q
`ifdef BITMAP_WRAP_FLAG_EN
  ,
  output logic               XWRAP,
  output logic               YWRAP
`endif
);

  bm_state_e  state_q;
  logic [3:0] ctl_d, ctl_q;
  logic       step;
  logic       x_wrap, y_wrap;

  // Step on the edge that ends the ce2Hd3 cycle, so the write commits pre-step.
  assign step = (state_q == StWait) && ce2Hd3 && !BITMDn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (!BITMDn) state_q <= StWait;
        StWait: begin
          if (BITMDn)      state_q <= StIdle;
          else if (ce2Hd3) state_q <= StHold;
        end
        StHold:  if (BITMDn) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ctl_d = ctl_q;
    if (!CTL_WEn) ctl_d = BD[3:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_q <= '0;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  bitmap_axis_counter #(
    .W (XW)
  ) u_x_axis (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (!XA_WEn),
    .load_val_i (XW'(BD)),
    .step_i     (step && ctl_q[CTL_AX]),
    .dec_i      (ctl_q[CTL_XDEC]),
    .cnt_o      (XA_q),
    .wrap_o     (x_wrap)
  );

  bitmap_axis_counter #(
    .W (YW)
  ) u_y_axis (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (!YA_WEn),
    .load_val_i (YW'(BD)),
    .step_i     (step && ctl_q[CTL_AY]),
    .dec_i      (ctl_q[CTL_YDEC]),
    .cnt_o      (YA_q),
    .wrap_o     (y_wrap)
  );

  assign DRBA = BITMDn ? AB : {YA_q, XA_q[XW-1:1]};
  assign PIXA = XA_q[0];

`ifdef BITMAP_WRAP_FLAG_EN
  logic xwrap_d, xwrap_q, ywrap_d, ywrap_q;

  // A control write clears the flags even if a wrap lands on the same edge.
  always_comb begin
    xwrap_d = xwrap_q | x_wrap;
    ywrap_d = ywrap_q | y_wrap;
    if (!CTL_WEn) begin
      xwrap_d = 1'b0;
      ywrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xwrap_q <= 1'b0;
      ywrap_q <= 1'b0;
    end else begin
      xwrap_q <= xwrap_d;
      ywrap_q <= ywrap_d;
    end
  end

  assign XWRAP = xwrap_q;
  assign YWRAP = ywrap_q;
`else
  logic unused_wrap;
  assign unused_wrap = x_wrap ^ y_wrap;
`endif

endmodule

// File: tb/tb_bitmap_addr_gen.sv
// Directed, table-driven bench for bitmap_addr_gen plus multi-cycle corner sequences.
module tb_bitmap_addr_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce2Hd3;
  logic [14:0] AB;
  logic [7:0]  BD;
  logic        XA_WEn, YA_WEn, CTL_WEn, BITMDn;
  logic [14:0] DRBA;
  logic        PIXA;
  logic [7:0]  XA_q, YA_q;
`ifdef BITMAP_WRAP_FLAG_EN
  logic        XWRAP, YWRAP;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bitmap_addr_gen #(
    .XW (8),
    .YW (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce2Hd3  (ce2Hd3),
    .AB      (AB),
    .BD      (BD),
    .XA_WEn  (XA_WEn),
    .YA_WEn  (YA_WEn),
    .CTL_WEn (CTL_WEn),
    .BITMDn  (BITMDn),
    .DRBA    (DRBA),
    .PIXA    (PIXA),
    .XA_q    (XA_q),
    .YA_q    (YA_q)
`ifdef BITMAP_WRAP_FLAG_EN
    ,
    .XWRAP   (XWRAP),
    .YWRAP   (YWRAP)
`endif
  );

  typedef struct {
    logic [7:0]  ctl;
    logic [7:0]  xa;
    logic [7:0]  ya;
    logic [14:0] exp_drba;
    logic        exp_pixa;
    logic [7:0]  exp_xa;
    logic [7:0]  exp_ya;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_xa(input logic [7:0] v);
    XA_WEn = 1'b0; BD = v; tick(); XA_WEn = 1'b1;
  endtask

  task automatic wr_ya(input logic [7:0] v);
    YA_WEn = 1'b0; BD = v; tick(); YA_WEn = 1'b1;
  endtask

  task automatic wr_ctl(input logic [7:0] v);
    CTL_WEn = 1'b0; BD = v; tick(); CTL_WEn = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'h10, 8'h20, 15'h1008, 1'b0, 8'h11, 8'h20};
    vecs[1] = '{8'h05, 8'h10, 8'h20, 15'h1008, 1'b0, 8'h0F, 8'h20};
    vecs[2] = '{8'h02, 8'h33, 8'h44, 15'h2219, 1'b1, 8'h33, 8'h45};
    vecs[3] = '{8'h0A, 8'h80, 8'h00, 15'h0040, 1'b0, 8'h80, 8'hFF};
    vecs[4] = '{8'h0F, 8'h00, 8'h00, 15'h0000, 1'b0, 8'hFF, 8'hFF};
    vecs[5] = '{8'h03, 8'hFF, 8'hFF, 15'h7FFF, 1'b1, 8'h00, 8'h00};
    vecs[6] = '{8'h0C, 8'h12, 8'h34, 15'h1A09, 1'b0, 8'h12, 8'h34};
    vecs[7] = '{8'h01, 8'h01, 8'h00, 15'h0000, 1'b1, 8'h02, 8'h00};

    reset_n = 1'b0; ce2Hd3 = 1'b0; AB = 15'h1234; BD = 8'h00;
    XA_WEn = 1'b1; YA_WEn = 1'b1; CTL_WEn = 1'b1; BITMDn = 1'b1;
    repeat (2) tick();
    check("reset_xa", {8'h0, XA_q}, 16'h0000);
    check("reset_ya", {8'h0, YA_q}, 16'h0000);
    check("reset_pixa", {15'h0, PIXA}, 16'h0000);
    check("reset_drba_ab", {1'b0, DRBA}, 16'h1234);
    reset_n = 1'b1;
    tick();

    // 1: bitmap address mux, control cleared so no step.
    wr_xa(8'h10); wr_ya(8'h20);
    BITMDn = 1'b0; tick();
    check("t1_drba", {1'b0, DRBA}, 16'h1008);
    check("t1_pixa", {15'h0, PIXA}, 16'h0000);
    ce2Hd3 = 1'b1; tick(); ce2Hd3 = 1'b0;
    BITMDn = 1'b1; tick();
    check("t1_nostep_xa", {8'h0, XA_q}, 16'h0010);
    check("t1_nomode_drba", {1'b0, DRBA}, 16'h1234);

    // Table: one access per vector, address before step and pointers after.
    for (int i = 0; i < 8; i++) begin
      wr_ctl(vecs[i].ctl); wr_xa(vecs[i].xa); wr_ya(vecs[i].ya);
      AB = 15'h2AAA;
      BITMDn = 1'b0; tick();
      tick();
      check($sformatf("v%0d_drba", i), {1'b0, DRBA}, {1'b0, vecs[i].exp_drba});
      check($sformatf("v%0d_pixa", i), {15'h0, PIXA}, {15'h0, vecs[i].exp_pixa});
      ce2Hd3 = 1'b1; tick(); ce2Hd3 = 1'b0;
      BITMDn = 1'b1; tick();
      check($sformatf("v%0d_xa", i), {8'h0, XA_q}, {8'h0, vecs[i].exp_xa});
      check($sformatf("v%0d_ya", i), {8'h0, YA_q}, {8'h0, vecs[i].exp_ya});
      check($sformatf("v%0d_ab_pass", i), {1'b0, DRBA}, 16'h2AAA);
    end

    // 2: one access spanning two ce2Hd3 strobes steps once.
    wr_ctl(8'h01); wr_xa(8'hFF); wr_ya(8'h5A);
`ifdef BITMAP_WRAP_FLAG_EN
    check("t2_wrap_clr", {15'h0, XWRAP}, 16'h0000);
`endif
    BITMDn = 1'b0; tick();
    ce2Hd3 = 1'b1; tick(); ce2Hd3 = 1'b0;
    repeat (7) tick();
    ce2Hd3 = 1'b1; tick(); ce2Hd3 = 1'b0;
    check("t2_xa_once", {8'h0, XA_q}, 16'h0000);
    check("t2_ya_same", {8'h0, YA_q}, 16'h005A);
    BITMDn = 1'b1; tick();
`ifdef BITMAP_WRAP_FLAG_EN
    check("t2_xwrap", {15'h0, XWRAP}, 16'h0001);
    check("t2_ywrap", {15'h0, YWRAP}, 16'h0000);
    wr_ctl(8'h01);
    check("t2_xwrap_ctl_clr", {15'h0, XWRAP}, 16'h0000);
`endif

    // 4: CPU XA write on the step edge wins; Y still steps.
    wr_ctl(8'h03); wr_xa(8'h10); wr_ya(8'h20);
    BITMDn = 1'b0; tick(); tick();
    ce2Hd3 = 1'b1; XA_WEn = 1'b0; BD = 8'h55; tick();
    ce2Hd3 = 1'b0; XA_WEn = 1'b1;
    BITMDn = 1'b1; tick();
    check("t4_xa_cpu_wins", {8'h0, XA_q}, 16'h0055);
    check("t4_ya_step", {8'h0, YA_q}, 16'h0021);

    // Control write on the step edge: step uses the old bits (increment).
    wr_ctl(8'h01); wr_xa(8'h10);
    BITMDn = 1'b0; tick();
    ce2Hd3 = 1'b1; CTL_WEn = 1'b0; BD = 8'h05; tick();
    ce2Hd3 = 1'b0; CTL_WEn = 1'b1;
    BITMDn = 1'b1; tick();
    check("t4_ctl_old_bits", {8'h0, XA_q}, 16'h0011);
    BITMDn = 1'b0; tick();
    ce2Hd3 = 1'b1; tick(); ce2Hd3 = 1'b0;
    BITMDn = 1'b1; tick();
    check("t4_ctl_new_bits", {8'h0, XA_q}, 16'h0010);

    // 5: abort before ce2Hd3; then a strobe in the first (IDLE) cycle must not step.
    BITMDn = 1'b0; tick();
    BITMDn = 1'b1; tick();
    ce2Hd3 = 1'b1; tick(); ce2Hd3 = 1'b0;
    check("t5_abort_nostep", {8'h0, XA_q}, 16'h0010);
    BITMDn = 1'b0; ce2Hd3 = 1'b1; tick(); ce2Hd3 = 1'b0;
    check("t5_idle_nostep", {8'h0, XA_q}, 16'h0010);
    BITMDn = 1'b1; tick();

    // 6: asynchronous reset during WAIT.
    wr_ctl(8'h03); wr_xa(8'h10); wr_ya(8'h20);
    BITMDn = 1'b0; tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_xa", {8'h0, XA_q}, 16'h0000);
    check("t6_async_ya", {8'h0, YA_q}, 16'h0000);
    tick();
    reset_n = 1'b1;
    ce2Hd3 = 1'b1; tick(); ce2Hd3 = 1'b0;
    BITMDn = 1'b1; tick();
    check("t6_release_xa", {8'h0, XA_q}, 16'h0000);
    check("t6_release_ya", {8'h0, YA_q}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
